// File: rtl/bus_cycle_responder_if.sv
// rtl/bus_cycle_responder_if.sv - 68000 slave-side bus signals between CPU pins and the responder
interface bus_cycle_responder_if;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        read;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        io_ready;
    logic        dtack_n;
    logic        berr_n;
    logic        rom_cs_n;
    logic        ram_cs_n;
    logic        io_cs_n;
    logic        oe_n;
    logic        we_hi_n;
    logic        we_lo_n;

    modport slave (
        input  as_n, uds_n, lds_n, read, addr, fc, io_ready,
        output dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n
    );

    modport master (
        output as_n, uds_n, lds_n, read, addr, fc, io_ready,
        input  dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n
    );
endinterface

// File: rtl/bus_cycle_responder.sv
// rtl/bus_cycle_responder.sv - 68000 slave glue: region decode, wait states, dtack/berr
// Optional bus-error and timeout logic is built when BERR_EN is defined.
module bus_cycle_responder #(
    parameter logic [3:0]  ROM_PAGE       = 4'h0,
    parameter logic [3:0]  RAM_PAGE       = 4'h1,
    parameter logic [3:0]  IO_PAGE        = 4'hF,
    parameter int unsigned ROM_WAIT       = 2,
    parameter int unsigned RAM_WAIT       = 0,
    parameter int unsigned IO_WAIT        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_cycle_responder_if.slave  bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_ACK, ST_BERR} state_t;
    typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM, RG_IO} region_t;

    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    state_t     state_q, state_d;
    region_t    region_q, region_d, region_dec;
    logic [3:0] wait_q, wait_d, wait_dec;
    logic       armed_q, armed_d;
    logic       read_q, read_d;
    logic       active, ack_ready;
    logic       dtack_n_q, dtack_n_d;
    logic       rom_cs_n_q, rom_cs_n_d;
    logic       ram_cs_n_q, ram_cs_n_d;
    logic       io_cs_n_q, io_cs_n_d;
    logic       oe_n_q, oe_n_d;
    logic       we_hi_n_q, we_hi_n_d;
    logic       we_lo_n_q, we_lo_n_d;
`ifdef BERR_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] timer_q, timer_d;
    logic       berr_n_q, berr_n_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif
    logic unused_addr;
    assign unused_addr = ^bus.addr[19:0];

    // Page match order gives ROM priority over RAM, and RAM over IO.
    always_comb begin
        region_dec = RG_NONE;
        wait_dec   = 4'd0;
        if (bus.fc != 3'b111) begin
            if (bus.addr[23:20] == ROM_PAGE) begin
                region_dec = RG_ROM;
                wait_dec   = ROM_W;
            end else if (bus.addr[23:20] == RAM_PAGE) begin
                region_dec = RG_RAM;
                wait_dec   = RAM_W;
            end else if (bus.addr[23:20] == IO_PAGE) begin
                region_dec = RG_IO;
                wait_dec   = IO_W;
            end
        end
    end

    assign ack_ready = (wait_q == 4'd0) && ((region_q != RG_IO) || bus.io_ready);

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        wait_d     = wait_q;
        read_d     = read_q;
        armed_d    = armed_q | bus.as_n;
        active     = 1'b0;
        dtack_n_d  = 1'b1;
        rom_cs_n_d = 1'b1;
        ram_cs_n_d = 1'b1;
        io_cs_n_d  = 1'b1;
        oe_n_d     = 1'b1;
        we_hi_n_d  = 1'b1;
        we_lo_n_d  = 1'b1;
`ifdef BERR_EN
        timer_d    = timer_q;
        berr_n_d   = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !bus.as_n) begin
                    region_d = region_dec;
                    read_d   = bus.read;
                    wait_d   = wait_dec;
                    state_d  = ST_DECODE;
`ifdef BERR_EN
                    timer_d  = 8'd0;
`endif
                end
            end
            ST_DECODE, ST_WAIT: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
`ifdef BERR_EN
                end else if (region_q == RG_NONE) begin
                    state_d  = ST_BERR;
                    berr_n_d = 1'b0;
`endif
                end else if (ack_ready) begin
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                    active    = 1'b1;
`ifdef BERR_EN
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d  = ST_BERR;
                    berr_n_d = 1'b0;
`endif
                end else begin
                    state_d = ST_WAIT;
                    active  = 1'b1;
                    if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
`ifdef BERR_EN
                    timer_d = timer_q + 8'd1;
`endif
                end
            end
            ST_ACK: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                    active    = 1'b1;
                end
            end
`ifdef BERR_EN
            ST_BERR: begin
                if (bus.as_n) state_d  = ST_IDLE;
                else          berr_n_d = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Write enables track the live byte strobes; region and direction stay latched.
        if (active) begin
            rom_cs_n_d = (region_q != RG_ROM);
            ram_cs_n_d = (region_q != RG_RAM);
            io_cs_n_d  = (region_q != RG_IO);
            oe_n_d     = ~read_q;
            we_hi_n_d  = ~(~read_q & ~bus.uds_n);
            we_lo_n_d  = ~(~read_q & ~bus.lds_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            region_q   <= RG_NONE;
            wait_q     <= 4'd0;
            read_q     <= 1'b1;
            armed_q    <= 1'b0;
            dtack_n_q  <= 1'b1;
            rom_cs_n_q <= 1'b1;
            ram_cs_n_q <= 1'b1;
            io_cs_n_q  <= 1'b1;
            oe_n_q     <= 1'b1;
            we_hi_n_q  <= 1'b1;
            we_lo_n_q  <= 1'b1;
`ifdef BERR_EN
            timer_q    <= 8'd0;
            berr_n_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            wait_q     <= wait_d;
            read_q     <= read_d;
            armed_q    <= armed_d;
            dtack_n_q  <= dtack_n_d;
            rom_cs_n_q <= rom_cs_n_d;
            ram_cs_n_q <= ram_cs_n_d;
            io_cs_n_q  <= io_cs_n_d;
            oe_n_q     <= oe_n_d;
            we_hi_n_q  <= we_hi_n_d;
            we_lo_n_q  <= we_lo_n_d;
`ifdef BERR_EN
            timer_q    <= timer_d;
            berr_n_q   <= berr_n_d;
`endif
        end
    end

    assign bus.dtack_n  = dtack_n_q;
    assign bus.rom_cs_n = rom_cs_n_q;
    assign bus.ram_cs_n = ram_cs_n_q;
    assign bus.io_cs_n  = io_cs_n_q;
    assign bus.oe_n     = oe_n_q;
    assign bus.we_hi_n  = we_hi_n_q;
    assign bus.we_lo_n  = we_lo_n_q;
`ifdef BERR_EN
    assign bus.berr_n   = berr_n_q;
`else
    assign bus.berr_n   = 1'b1;
`endif
endmodule

// File: tb/tb_bus_cycle_responder.sv
// tb/tb_bus_cycle_responder.sv - randomized bus cycles checked against a transaction-level timing model
module tb_bus_cycle_responder;
    localparam int ROM_WAIT = 2;
    localparam int RAM_WAIT = 0;
    localparam int IO_WAIT  = 1;
    localparam int TIMEOUT  = 64;
    localparam int NEVER    = 1000;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_id  = 0;

    bus_cycle_responder_if bus();

    bus_cycle_responder #(
        .ROM_PAGE(4'h0), .RAM_PAGE(4'h1), .IO_PAGE(4'hF),
        .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got[7:0], exp[7:0]);
        end
    endtask

    // {dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n}
    function automatic logic [7:0] outs();
        return {bus.dtack_n, bus.berr_n, bus.rom_cs_n, bus.ram_cs_n,
                bus.io_cs_n, bus.oe_n, bus.we_hi_n, bus.we_lo_n};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus cycle: as_n sampled low on edges E0..E0+n-1, high on E0+n.
    // io_mode: 0 random, 1 always ready, 2 ready from E0+5, 3 never ready.
    // sm: 0 random strobes, 1 both low, 2 uds high / lds low.
    task automatic run_cycle(input logic [23:0] a, input logic [2:0] f, input logic rd,
                             input int n, input int io_mode, input int sm);
        logic u [0:79];
        logic l [0:79];
        logic r [0:79];
        int   rg, a_edge, b_edge;
        logic act, berr_build;
        logic [7:0] exp;
`ifdef BERR_EN
        berr_build = 1'b1;
`else
        berr_build = 1'b0;
`endif
        cyc_id++;
        for (int k = 0; k <= n; k++) begin
            case (sm)
                1:       begin u[k] = 1'b0; l[k] = 1'b0; end
                2:       begin u[k] = 1'b1; l[k] = 1'b0; end
                default: begin u[k] = 1'($urandom); l[k] = 1'($urandom); end
            endcase
            case (io_mode)
                1:       r[k] = 1'b1;
                2:       r[k] = (k >= 5);
                3:       r[k] = 1'b0;
                default: r[k] = 1'($urandom);
            endcase
        end

        if (f == 3'b111)             rg = 0;
        else if (a[23:20] == 4'h0)   rg = 1;
        else if (a[23:20] == 4'h1)   rg = 2;
        else if (a[23:20] == 4'hF)   rg = 3;
        else                         rg = 0;

        a_edge = NEVER;
        b_edge = NEVER;
        case (rg)
            1: a_edge = 1 + ROM_WAIT;
            2: a_edge = 1 + RAM_WAIT;
            3: for (int k = n - 1; k >= 1 + IO_WAIT; k--) if (r[k]) a_edge = k;
            default: a_edge = berr_build ? NEVER : 1;
        endcase
        if (berr_build) begin
            if (rg == 0) b_edge = 1;
            else if (a_edge > TIMEOUT) begin
                b_edge = TIMEOUT;
                a_edge = NEVER;
            end
        end

        bus.addr = a;
        bus.fc   = f;
        bus.read = rd;
        for (int k = 0; k <= n; k++) begin
            bus.as_n     = (k < n) ? 1'b0 : 1'b1;
            bus.uds_n    = u[k];
            bus.lds_n    = l[k];
            bus.io_ready = r[k];
            tick();
            exp = 8'hFF;
            if (k >= 1 && k < n) begin
                act = (k < b_edge) && !(berr_build && rg == 0);
                exp = {~(k >= a_edge), ~(k >= b_edge),
                       ~(act && rg == 1), ~(act && rg == 2), ~(act && rg == 3),
                       ~(act && rd), ~(act && !rd && !u[k]), ~(act && !rd && !l[k])};
            end
            check($sformatf("cyc%0d_edge%0d", cyc_id, k), outs(), exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.as_n     = 1'b1;
        bus.uds_n    = 1'b1;
        bus.lds_n    = 1'b1;
        bus.read     = 1'b1;
        bus.addr     = 24'h0;
        bus.fc       = 3'd5;
        bus.io_ready = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 8'hFF);

        // as_n already low when reset releases: must not be acknowledged until it rises.
        bus.addr  = 24'h000100;
        bus.as_n  = 1'b0;
        reset     = 1'b0;
        repeat (4) begin
            tick();
            check("unarmed", outs(), 8'hFF);
        end
        bus.as_n = 1'b1;
        tick();

        run_cycle(24'h000100, 3'd5, 1'b1, 5, 0, 0);
        run_cycle(24'h100000, 3'd5, 1'b0, 3, 0, 1);
        run_cycle(24'h100000, 3'd5, 1'b0, 3, 0, 2);
        run_cycle(24'hF00010, 3'd5, 1'b1, 8, 2, 0);
        run_cycle(24'hF00010, 3'd5, 1'b1, 4, 1, 0);
        run_cycle(24'h500000, 3'd5, 1'b1, 4, 0, 0);
        run_cycle(24'h000000, 3'd7, 1'b1, 4, 0, 0);
        run_cycle(24'hF00020, 3'd1, 1'b0, 70, 3, 1);
        run_cycle(24'h000100, 3'd5, 1'b1, 2, 0, 0);

        // Reset while a ROM cycle is waiting, as_n held low throughout.
        bus.addr = 24'h000200;
        bus.fc   = 3'd5;
        bus.read = 1'b1;
        bus.as_n = 1'b0;
        tick();
        tick();
        check("rst_pre", outs(), 8'b1101_1011);
        reset = 1'b1;
        tick();
        check("rst_mid", outs(), 8'hFF);
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("rst_hold", outs(), 8'hFF);
        end
        bus.as_n = 1'b1;
        tick();
        check("rst_rearm", outs(), 8'hFF);
        run_cycle(24'h000300, 3'd5, 1'b1, 4, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] pg;
            logic [2:0] f;
            int sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       pg = 4'h0;
                1:       pg = 4'h1;
                2, 3:    pg = 4'hF;
                default: pg = 4'(4'h2 + $urandom_range(0, 12));
            endcase
            f = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            run_cycle({pg, 20'($urandom)}, f, 1'($urandom), $urandom_range(1, 8), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
